// File: rtl/stdp_pkg.sv
// Shared definitions for the LIF neuron and the STDP learning block.
//   lif_state_t : neuron FSM state encoding
//   WEIGHT_W    : synaptic weight width shared with the STDP block
//   DEF_*       : default neuron parameters
package stdp_pkg;

  typedef enum logic [1:0] {
    ST_INTEGRATE  = 2'd0,
    ST_FIRE       = 2'd1,
    ST_REFRACTORY = 2'd2
  } lif_state_t;

  localparam int WEIGHT_W = 8;

  localparam int DEF_V_WIDTH     = 10;
  localparam int DEF_THRESHOLD   = 64;
  localparam int DEF_LEAK_SHIFT  = 3;
  localparam int DEF_LEAK_PERIOD = 4;
  localparam int DEF_REFRACT     = 4;

endpackage

// File: rtl/lif_membrane_update.sv
// Combinational membrane update for the LIF neuron: leak, weighted add with
// saturation, and threshold compare.
// Ports:
//   v         in  V_WIDTH   current membrane potential
//   pre_spike in  1         pre-synaptic spike
//   weight    in  WEIGHT_W  synaptic weight added when pre_spike is high
//   leak_tick in  1         apply leak this cycle
//   v_n       out V_WIDTH   updated (saturated) membrane potential
//   fire      out 1         v_n has reached THRESHOLD
module lif_membrane_update
  import stdp_pkg::*;
#(
  parameter int V_WIDTH    = DEF_V_WIDTH,
  parameter int THRESHOLD  = DEF_THRESHOLD,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
  input  logic [V_WIDTH-1:0]  v,
  input  logic                pre_spike,
  input  logic [WEIGHT_W-1:0] weight,
  input  logic                leak_tick,
  output logic [V_WIDTH-1:0]  v_n,
  output logic                fire
);

  // One extra bit over the wider operand so the add cannot wrap.
  localparam int SW = ((V_WIDTH > WEIGHT_W) ? V_WIDTH : WEIGHT_W) + 1;

  logic [V_WIDTH-1:0] w_shift;
  logic [V_WIDTH-1:0] w_dec;
  logic [V_WIDTH-1:0] w_v_leak;
  logic [SW-1:0]      w_sum;

  always_comb begin
    w_shift = v >> LEAK_SHIFT;
    // Leak removes at least 1 so small potentials still decay to zero.
    w_dec   = (w_shift == '0) ? V_WIDTH'(1) : w_shift;
    w_v_leak = (leak_tick && (v != '0)) ? (v - w_dec) : v;
    w_sum = {{(SW-V_WIDTH){1'b0}}, w_v_leak}
          + (pre_spike ? {{(SW-WEIGHT_W){1'b0}}, weight} : '0);
    if (w_sum > {{(SW-V_WIDTH){1'b0}}, {V_WIDTH{1'b1}}}) begin
      v_n = '1;
    end else begin
      v_n = w_sum[V_WIDTH-1:0];
    end
    fire = (v_n >= V_WIDTH'(THRESHOLD));
  end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron driving the STDP post-synaptic input.
// Ports:
//   clk         in  1         clock, rising edge
//   rst_n       in  1         asynchronous active-low reset
//   en          in  1         enable; low freezes all state
//   pre_spike   in  1         pre-synaptic spike
//   weight      in  8         synaptic weight, sampled with pre_spike
//   post_spike  out 1         one-cycle fire pulse
//   membrane    out V_WIDTH   membrane potential
//   refractory  out 1         high in FIRE and REFRACTORY
//   spike_count out 8         saturating fire count since reset
module lif_neuron
  import stdp_pkg::*;
#(
  parameter int V_WIDTH     = DEF_V_WIDTH,
  parameter int THRESHOLD   = DEF_THRESHOLD,
  parameter int LEAK_SHIFT  = DEF_LEAK_SHIFT,
  parameter int LEAK_PERIOD = DEF_LEAK_PERIOD,
  parameter int REFRACT     = DEF_REFRACT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                pre_spike,
  input  logic [WEIGHT_W-1:0] weight,
  output logic                post_spike,
  output logic [V_WIDTH-1:0]  membrane,
  output logic                refractory,
  output logic [7:0]          spike_count
);

  localparam int TW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  lif_state_t         r_state, w_nx_state;
  logic [V_WIDTH-1:0] r_membrane, w_nx_membrane;
  logic [TW-1:0]      r_timer, w_nx_timer;
  logic [RW-1:0]      r_rcnt, w_nx_rcnt;
  logic [7:0]         r_count, w_nx_count;
  logic               r_post;
  logic               r_refr;

  logic               w_leak_tick;
  logic [V_WIDTH-1:0] w_v_n;
  logic               w_fire;

  assign w_leak_tick = (r_timer == TW'(LEAK_PERIOD - 1));

  lif_membrane_update #(
    .V_WIDTH    (V_WIDTH),
    .THRESHOLD  (THRESHOLD),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_update (
    .v         (r_membrane),
    .pre_spike (pre_spike),
    .weight    (weight),
    .leak_tick (w_leak_tick),
    .v_n       (w_v_n),
    .fire      (w_fire)
  );

  always_comb begin
    w_nx_state    = r_state;
    w_nx_membrane = r_membrane;
    w_nx_rcnt     = r_rcnt;
    w_nx_count    = r_count;
    w_nx_timer    = w_leak_tick ? '0 : (r_timer + TW'(1));
    case (r_state)
      ST_INTEGRATE: begin
        if (w_fire) begin
          w_nx_state    = ST_FIRE;
          w_nx_membrane = '0;
          if (r_count != 8'hFF) w_nx_count = r_count + 8'd1;
        end else begin
          w_nx_membrane = w_v_n;
        end
      end
      ST_FIRE: begin
        w_nx_membrane = '0;
        if (REFRACT == 0) begin
          w_nx_state = ST_INTEGRATE;
        end else begin
          w_nx_state = ST_REFRACTORY;
          w_nx_rcnt  = RW'(REFRACT);
        end
      end
      ST_REFRACTORY: begin
        w_nx_membrane = '0;
        if (r_rcnt <= RW'(1)) begin
          w_nx_state = ST_INTEGRATE;
          w_nx_rcnt  = '0;
        end else begin
          w_nx_rcnt = r_rcnt - RW'(1);
        end
      end
      default: begin
        w_nx_state    = ST_INTEGRATE;
        w_nx_membrane = '0;
        w_nx_rcnt     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INTEGRATE;
      r_membrane <= '0;
      r_timer    <= '0;
      r_rcnt     <= '0;
      r_count    <= '0;
      r_post     <= 1'b0;
      r_refr     <= 1'b0;
    end else if (en) begin
      r_state    <= w_nx_state;
      r_membrane <= w_nx_membrane;
      r_timer    <= w_nx_timer;
      r_rcnt     <= w_nx_rcnt;
      r_count    <= w_nx_count;
      r_post     <= (w_nx_state == ST_FIRE);
      r_refr     <= (w_nx_state != ST_INTEGRATE);
    end
  end

  // r_post is held with the rest of the state while disabled and masked at
  // the output, so a FIRE interrupted by en=0 yields its single pulse in the
  // first enabled cycle after en returns.
  assign post_spike  = r_post & en;
  assign membrane    = r_membrane;
  assign refractory  = r_refr;
  assign spike_count = r_count;

endmodule
